// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, baud codes
// and the index-width helper used to size requester indices.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BAUD_SLOWEST = 2'b00,
        BAUD_SLOW    = 2'b01,
        BAUD_FAST    = 2'b10,
        BAUD_FASTEST = 2'b11
    } baud_e;

    localparam baud_e BAUD_RESET = BAUD_FAST;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: searches upward from last_winner+1 (mod NREQ)
// and returns the first active request as a one-hot grant plus its index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]              req,
    input  logic [idx_width(NREQ)-1:0]   last_winner,
    output logic [NREQ-1:0]              grant,
    output logic [idx_width(NREQ)-1:0]   winner,
    output logic                         any
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [IW-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_winner) + k) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ requesters: round-robin grant, baud
// switch with settle delay, start pulse, and tx_done wait with timeout.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [2*NREQ-1:0] req_baud,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        baud_rate,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    baud_e             baud_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              err_q;
    logic [IW-1:0]     last_q;
    logic [SW-1:0]     settle_q, settle_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_winner;
    logic              arb_any;

    logic [7:0]        data_arr [NREQ];
    baud_e             baud_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[8*g +: 8];
        assign baud_arr[g] = baud_e'(req_baud[2*g +: 2]);
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req         (req),
        .last_winner (last_q),
        .grant       (arb_grant),
        .winner      (arb_winner),
        .any         (arb_any)
    );

    assign settle_d = settle_q + SW'(1);
    assign tmo_d    = tmo_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            baud_q     <= BAUD_RESET;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
            last_q     <= IW'(NREQ - 1);
            settle_q   <= '0;
            tmo_q      <= '0;
        end else begin
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q     <= arb_grant;
                        tx_data_q <= data_arr[arb_winner];
                        last_q    <= arb_winner;
                        if (baud_arr[arb_winner] != baud_q) begin
                            baud_q   <= baud_arr[arb_winner];
                            settle_q <= '0;
                            state_q  <= ST_SETTLE;
                        end else begin
                            state_q  <= ST_START;
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_q <= settle_d;
                    if (settle_d == SW'(SETTLE_CYC)) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start_q <= 1'b1;
                    tmo_q      <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // tx_done takes priority over a coincident timeout expiry
                    if (tx_done) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                        if (tmo_d == TW'(TIMEOUT_CYC)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign baud_rate   = baud_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != ST_IDLE);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_start_wait: assert property (@(posedge clk) disable iff (rst) tx_start_q |-> (state_q == ST_WAIT));
    a_err_idle:   assert property (@(posedge clk) disable iff (rst) err_q |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a timestamp-based transaction model.
module tb_uart_tx_scheduler;

    localparam int NREQ   = 4;
    localparam int SETTLE = 4;
    localparam int TMO    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_baud;
    logic        tx_done;
    logic [3:0]  gnt;
    logic [1:0]  baud_rate;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        err_timeout;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    uart_tx_scheduler #(
        .NREQ        (NREQ),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_baud    (req_baud),
        .gnt         (gnt),
        .baud_rate   (baud_rate),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: on each select it predicts the absolute cycles of
    // grant, start and (if no tx_done) timeout, then compares every cycle.
    bit         m_active = 1'b0;
    int         m_g = -1, m_s = -1, m_err = -1, m_w = 0, m_last = NREQ - 1;
    int         cyc_n = 0;
    logic [1:0] m_baud = 2'b10;
    logic [7:0] m_data = 8'h00;

    always @(negedge clk) begin
        logic [1:0] rb;
        bit         found;
        if (chk_en) begin
            chk("gnt",         gnt,         (cyc_n == m_g) ? (32'd1 << m_w) : 32'd0);
            chk("tx_start",    tx_start,    32'(cyc_n == m_s));
            chk("err_timeout", err_timeout, 32'(cyc_n == m_err));
            chk("busy",        busy,        32'(m_active));
            chk("baud_rate",   baud_rate,   m_baud);
            chk("tx_data",     tx_data,     m_data);
        end
        if (rst) begin
            m_active = 1'b0;
            m_g      = -1;
            m_s      = -1;
            m_err    = -1;
            m_baud   = 2'b10;
            m_data   = 8'h00;
            m_last   = NREQ - 1;
        end else if (!m_active) begin
            if (req != 4'b0000) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req[(m_last + k) % NREQ]) begin
                        m_w   = (m_last + k) % NREQ;
                        found = 1'b1;
                    end
                end
                rb       = req_baud[2*m_w +: 2];
                m_last   = m_w;
                m_active = 1'b1;
                m_g      = cyc_n + 1;
                m_s      = cyc_n + 2 + ((rb != m_baud) ? SETTLE : 0);
                m_baud   = rb;
                m_data   = req_data[8*m_w +: 8];
            end
        end else if (cyc_n >= m_s) begin
            if (tx_done) begin
                m_active = 1'b0;
            end else if (cyc_n == m_s + TMO - 1) begin
                m_active = 1'b0;
                m_err    = cyc_n + 1;
            end
        end
        cyc_n++;
    end

    int         cd = 0;
    int         ng, lat, s, e_at, n_e, d;
    logic [3:0] order [5];
    logic [3:0] b_exp [5];

    task automatic drain();
        req = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (tx_start) cd = 3;
            @(posedge clk); #1;
            if (cd > 0) begin cd--; tx_done = (cd == 0); end else tx_done = 1'b0;
        end
        chk("drain_idle", busy, 0);
        @(posedge clk); #1;
        tx_done = 1'b0;
        cd      = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req = '0; req_data = '0; req_baud = 8'hAA; tx_done = 1'b0;
        b_exp[0] = 4'b0001; b_exp[1] = 4'b0010; b_exp[2] = 4'b0100;
        b_exp[3] = 4'b1000; b_exp[4] = 4'b0001;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_baud", baud_rate, 2'b10);
        chk("rst_data", tx_data, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_err", err_timeout, 0);

        // single requester 0 at the reset baud code, request dropped after grant
        @(posedge clk); #1 req = 4'b0001; req_data[7:0] = 8'hA5;
        @(negedge clk); chk("A_gnt_early", gnt, 0);
        @(posedge clk); #1 req = 4'b0000;
        @(negedge clk);
        chk("A_gnt", gnt, 4'b0001);
        chk("A_baud", baud_rate, 2'b10);
        chk("A_start_early", tx_start, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("A_start", tx_start, 1);
        chk("A_data", tx_data, 8'hA5);
        @(posedge clk); #1 tx_done = 1'b1;
        @(negedge clk); chk("A_start_once", tx_start, 0);
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        chk("A_idle", busy, 0);
        chk("A_no_regrant", gnt, 0);
        chk("A_baud_kept", baud_rate, 2'b10);

        // all requesters held after a fresh reset, tx_done 5 cycles after each start
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req = 4'b1111; req_data = 32'h44332211; cd = 0;
        ng = 0;
        for (int k = 0; k < 300 && ng < 5; k++) begin
            @(negedge clk);
            if (gnt != 4'b0000) begin order[ng] = gnt; ng++; end
            if (tx_start) cd = 5;
            @(posedge clk); #1;
            if (cd > 0) begin cd--; tx_done = (cd == 0); end else tx_done = 1'b0;
        end
        chk("B_count", ng, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("B_order_%0d", i), order[i], b_exp[i]);
        drain();

        // requester 2 at the slowest code forces a settle period
        @(posedge clk); #1 req = 4'b0100; req_baud[5:4] = 2'b00; req_data[23:16] = 8'h5C;
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("C_gnt", gnt, 4'b0100);
                chk("C_baud_select", baud_rate, 2'b00);
            end
            if (tx_start) lat = k;
            @(posedge clk); #1;
            if (gnt != 4'b0000) req = '0;
            tx_done = (lat >= 0);
        end
        chk("C_latency", lat, SETTLE + 2);
        drain();

        // no tx_done: timeout pulse exactly TMO cycles after start
        @(posedge clk); #1 req = 4'b0010; req_baud[3:2] = 2'b00; req_data[15:8] = 8'h3D;
        s = -1; e_at = -1; n_e = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_start) s = k;
            if (err_timeout) begin n_e++; e_at = k; end
            if (s >= 0 && k == s + TMO) chk("D1_idle", busy, 0);
            @(posedge clk); #1;
            if (gnt != 4'b0000) req = '0;
        end
        chk("D1_latency", s, 2);
        chk("D1_err_count", n_e, 1);
        chk("D1_err_pos", e_at - s, TMO);

        // tx_done in the final wait cycle suppresses the timeout
        @(posedge clk); #1 req = 4'b1000; req_baud[7:6] = 2'b00; req_data[31:24] = 8'hD2;
        s = -1; n_e = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_start) s = k;
            if (err_timeout) n_e++;
            if (s >= 0 && k == s + TMO) chk("D2_idle", busy, 0);
            @(posedge clk); #1;
            if (gnt != 4'b0000) req = '0;
            tx_done = (s >= 0 && k + 1 == s + TMO - 1);
        end
        chk("D2_latency", s, 2);
        chk("D2_err_count", n_e, 0);

        // reset while waiting for tx_done, then a stray tx_done
        @(posedge clk); #1 req = 4'b0001; req_baud[1:0] = 2'b01; req_data[7:0] = 8'hE7;
        s = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_start) begin s = k; break; end
            @(posedge clk); #1;
            if (gnt != 4'b0000) req = '0;
        end
        chk("E_latency", s, SETTLE + 2);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("E_busy", busy, 0);
        chk("E_baud", baud_rate, 2'b10);
        chk("E_data", tx_data, 0);
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("E_stray_busy", busy, 0);
            chk("E_stray_gnt", gnt, 0);
            chk("E_stray_start", tx_start, 0);
        end

        // randomized traffic with varied response delays, strays and resets
        cd = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req      = 4'($urandom) & 4'($urandom);
                req_data = $urandom;
                req_baud = 8'($urandom);
            end
            if (cd > 0) begin cd--; tx_done = (cd == 0); end
            else tx_done = ($urandom_range(0, 63) == 0);
            if (tx_start) begin
                d = $urandom_range(0, 22);
                if (d == 0) tx_done = 1'b1; else cd = d;
            end
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing the transmitter.
REQ-002 Parameter: SETTLE_CYC, default 4, cycles baud_rate is held stable before a start after a rate change.
REQ-003 Parameter: TIMEOUT_CYC, default 65535, maximum cycles waited for tx_done after tx_start.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester transmit request, level.
REQ-007 req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i].
REQ-008 req_baud  in  2*NREQ  baud code for requester i at bits [2i+1:2i]; 00=slowest … 11=fastest.
REQ-009 gnt  out  NREQ  one-hot, one-cycle pulse: request accepted, data captured.
REQ-010 baud_rate  out  2  registered baud code driven to the baud generator.
REQ-011 tx_start  out  1  one-cycle pulse to the transmitter.
REQ-012 tx_data  out  8  byte to the transmitter, stable from grant until return to IDLE.
REQ-013 tx_done  in  1  one-cycle pulse from the transmitter: frame complete.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err_timeout  out  1  one-cycle pulse when TIMEOUT_CYC expires.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, START and WAIT.
REQ-017 IDLE with any req bit high SHALL select the winner round-robin, searching from (last_winner+1) mod NREQ upward.
REQ-018 In the select cycle: gnt[winner] pulses, tx_data <= req_data[winner], last_winner <= winner.
REQ-019 If req_baud[winner] != baud_rate: baud_rate <= req_baud[winner], settle counter loads 0, go to SETTLE; otherwise go to START.
REQ-020 SETTLE SHALL increment the counter each cycle and go to START once SETTLE_CYC cycles have elapsed in SETTLE.
REQ-021 START SHALL assert tx_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-022 WAIT with tx_done high SHALL return to IDLE.
REQ-023 WAIT SHALL pulse err_timeout and return to IDLE when the timeout counter reaches TIMEOUT_CYC without tx_done.
REQ-024 If tx_done and timeout expiry coincide, tx_done SHALL win and err_timeout SHALL stay low.
REQ-025 tx_done outside WAIT SHALL be ignored.
REQ-026 baud_rate SHALL change only in the IDLE select cycle, never during SETTLE, START or WAIT.
REQ-027 Request-to-tx_start latency SHALL be 2 cycles with no rate change and SETTLE_CYC+2 cycles with a rate change.
REQ-028 Requests SHALL be sampled only in IDLE; req deassertion after grant SHALL NOT affect the transfer.
REQ-029 The minimum gap between consecutive grants SHALL be one IDLE cycle.
REQ-030 Counters SHALL be sized to hold TIMEOUT_CYC and SETTLE_CYC without wrap.

Reset
REQ-031 Reset SHALL force: state IDLE, gnt 0, tx_start 0, tx_data 0, busy 0, err_timeout 0, baud_rate 2'b10, last_winner NREQ-1 (requester 0 first), all counters 0.
REQ-032 Reset asserted mid-transfer SHALL abort it within one cycle; the aborted requester SHALL receive no further gnt.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state encoding, the baud code constants and the reset baud code 2'b10.
REQ-034 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs: req, last_winner; outputs: one-hot grant, winner index, any).

Verification
REQ-035 Single req[0], req_baud[0]=10 after reset -> gnt=0001, tx_start 2 cycles later, tx_data matches, no baud change.
REQ-036 req=1111 held, tx_done returned 5 cycles after each tx_start -> gnt order 0001,0010,0100,1000,0001.
REQ-037 req[2] with req_baud[2]=00 (current 10) -> baud_rate=00 in the select cycle, tx_start exactly SETTLE_CYC+2 cycles after the request.
REQ-038 TIMEOUT_CYC=20, tx_done never returned -> err_timeout pulses once, 20 cycles after tx_start, then IDLE; tx_done on that same cycle -> no err_timeout.
REQ-039 rst pulsed during WAIT -> next cycle busy=0, baud_rate=10, tx_data=0; a later stray tx_done has no effect.
REQ-040 req dropped the cycle after gnt -> tx_start still issued with the captured byte.
